sync_event_arbiter: RTL and testbench

Collects rising-edge events from up to NumIn asynchronous single-bit sources and hands them to one synchronous consumer, one at a time, in round-robin order. Each source passes through its own STAGES-deep synchronizer with edge detection. Each detected edge is latched as a pending bit, and the pending bits share a single registered valid/ready event port. The block sits at the boundary between asynchronous status/interrupt wires and the crossbar's control logic.

---
 rtl/sync_event_arbiter_if.sv | 40 ++++
 rtl/sync_event_arbiter.sv | 136 +++++++++++++
 tb/tb_sync_event_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// sync_event_arbiter_if
//   Bundles the asynchronous source lines, the per-source mask, the
//   valid/ready event port and the overflow status of sync_event_arbiter.
//
//   async_i      asynchronous source lines (one bit per source)
//   mask_i       1 = drop new edges from that source
//   evt_valid_o  an event is presented
//   evt_ready_i  consumer accepts the presented event
//   evt_idx_o    source index of the presented event
//   pending_o    at least one source has a captured, undelivered edge
//   ovf_o        sticky per-source overflow flags
//   ovf_clr_i    clears every overflow flag
//
//   slave  : the arbiter side
//   master : the side driving sources and consuming events
// -----------------------------------------------------------------------------
interface sync_event_arbiter_if #(
   parameter int NumIn = 4,
   parameter int IdxW  = (NumIn > 1) ? $clog2(NumIn) : 1
);
   logic [NumIn-1:0] async_i;
   logic [NumIn-1:0] mask_i;
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [IdxW-1:0]  evt_idx_o;
   logic             pending_o;
   logic [NumIn-1:0] ovf_o;
   logic             ovf_clr_i;

   modport slave (
      input  async_i, mask_i, evt_ready_i, ovf_clr_i,
      output evt_valid_o, evt_idx_o, pending_o, ovf_o
   );

   modport master (
      output async_i, mask_i, evt_ready_i, ovf_clr_i,
      input  evt_valid_o, evt_idx_o, pending_o, ovf_o
   );
endinterface

// File: rtl/sync_event_arbiter.sv
// -----------------------------------------------------------------------------
// sync_event_arbiter
//   Synchronizes NumIn asynchronous single-bit sources, detects their rising
//   edges, latches each edge as a pending bit and delivers the pending events
//   one at a time, round-robin, over a registered valid/ready port.
//
//   Parameters
//     NumIn       number of asynchronous sources (>= 1)
//     STAGES      synchronizer flops per source (>= 2)
//     ResetValue  reset value of every synchronizer and edge-detect flop
//
//   Ports
//     clk_i   clock, all state updates on the rising edge
//     rst_ni  asynchronous active-low reset
//     bus     sync_event_arbiter_if.slave (sources, mask, event port, overflow)
// -----------------------------------------------------------------------------
module sync_event_arbiter #(
   parameter int   NumIn      = 4,
   parameter int   STAGES     = 2,
   parameter logic ResetValue = 1'b0,
   localparam int  IdxW       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   sync_event_arbiter_if.slave bus
);

   // ---------------------------------------------------------------------------
   // Synchronizer and edge detection
   // ---------------------------------------------------------------------------
   // Stage 0 samples async_i; stage STAGES-1 is the synchronized value.
   logic [STAGES-1:0][NumIn-1:0] sync_q;
   logic [NumIn-1:0]             sync_s;
   logic [NumIn-1:0]             prev_q;
   logic [NumIn-1:0]             edge_det;
   logic [NumIn-1:0]             capture;

   assign sync_s   = sync_q[STAGES-1];
   assign edge_det = sync_s & ~prev_q;
   assign capture  = edge_det & ~bus.mask_i;

   // NOTE: the synchronizer flops take ResetValue too; with ResetValue = 1 a
   // line held high through reset then looks "already high" and yields no edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {(STAGES*NumIn){ResetValue}};
         prev_q <= {NumIn{ResetValue}};
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift chain.
         sync_q <= {sync_q[STAGES-2:0], bus.async_i};
         prev_q <= sync_s;
      end
   end

   // ---------------------------------------------------------------------------
   // Pending bits, round-robin grant, overflow
   // ---------------------------------------------------------------------------
   logic [NumIn-1:0] pend_q, pend_d;
   logic [NumIn-1:0] ovf_q, ovf_d, ovf_set;
   logic [NumIn-1:0] clr_vec;
   logic [IdxW-1:0]  ptr_q, ptr_next;
   logic [IdxW-1:0]  grant, grant_any, grant_hi;
   logic             hi_found;
   logic             load;
   logic             valid_q;
   logic [IdxW-1:0]  idx_q;

   // The output register may be refilled when empty or when it is being
   // handed off in this same cycle.
   assign load = (|pend_q) & (~valid_q | bus.evt_ready_i);

   // Cyclic search from ptr_q: the lowest pending index at or above ptr_q
   // wins; if there is none the search wraps to the lowest pending index.
   // NOTE: every variable gets a default before the loop so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      grant_any = '0;
      grant_hi  = '0;
      hi_found  = 1'b0;
      // Descending scan: the last hit is the lowest index.
      for (int i = NumIn - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            grant_any = IdxW'(i);
            if (IdxW'(i) >= ptr_q) begin
               grant_hi = IdxW'(i);
               hi_found = 1'b1;
            end
         end
      end
      grant = hi_found ? grant_hi : grant_any;
   end

   assign ptr_next = (grant == IdxW'(NumIn - 1)) ? '0 : grant + 1'b1;

   always_comb begin
      clr_vec = '0;
      if (load) begin
         clr_vec[grant] = 1'b1;
      end
   end

   // An edge arriving while its own bit is being loaded keeps the bit set;
   // an edge on a source whose event already sits in the output register
   // finds pend_q clear and is simply re-captured.
   assign pend_d  = (pend_q & ~clr_vec) | capture;
   assign ovf_set = capture & pend_q & ~clr_vec;
   // Set has priority over clear.
   assign ovf_d   = (bus.ovf_clr_i ? '0 : ovf_q) | ovf_set;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q  <= '0;
         ovf_q   <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         if (load) begin
            valid_q <= 1'b1;
            idx_q   <= grant;
            ptr_q   <= ptr_next;
         end else if (bus.evt_ready_i) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.evt_valid_o = valid_q;
   assign bus.evt_idx_o   = idx_q;
   assign bus.pending_o   = |pend_q;
   assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_sync_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_event_arbiter
//   Directed scenarios followed by randomized traffic. A behavioural model
//   (async history queue, pending bit array, cyclic search) predicts every
//   delivered event into a scoreboard queue; a negedge monitor pops and
//   compares on each DUT handshake and also compares valid/pending/ovf.
//   A second instance with ResetValue = 1 has its lines held high throughout
//   and must never report anything.
// -----------------------------------------------------------------------------
module tb_sync_event_arbiter;
   localparam int N = 4;
   localparam int S = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sync_event_arbiter_if #(.NumIn(N)) bus ();
   sync_event_arbiter_if #(.NumIn(N)) bus1 ();

   sync_event_arbiter #(.NumIn(N), .STAGES(S), .ResetValue(1'b0)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   sync_event_arbiter #(.NumIn(N), .STAGES(S), .ResetValue(1'b1)) dut_rv1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [N-1:0] hist[$];     // async value sampled at each edge, newest last
   logic [N-1:0] m_pend, m_ovf;
   int           m_ptr, m_idx;
   bit           m_valid;
   int           exp_q[$];    // predicted handshakes, in order
   int           seen_q[$];   // observed handshakes, for directed checks

   // Values the DUT should be showing during the current cycle.
   bit           obs_valid    = 1'b0;
   int           obs_idx      = 0;
   bit           obs_pend_any = 1'b0;
   logic [N-1:0] obs_ovf      = '0;

   task automatic model_reset();
      hist = {};
      for (int k = 0; k <= S; k++) hist.push_back('0);
      m_pend = '0; m_ovf = '0; m_ptr = 0; m_idx = 0; m_valid = 1'b0;
      obs_valid = 1'b0; obs_idx = 0; obs_pend_any = 1'b0; obs_ovf = '0;
   endtask

   task automatic model_step();
      logic [N-1:0] rise, cap, taken, set_ovf;
      int g;
      bit ld;
      obs_valid = m_valid; obs_idx = m_idx; obs_pend_any = (m_pend != '0); obs_ovf = m_ovf;
      // Handshake completes at the coming edge.
      if (m_valid && bus.evt_ready_i) exp_q.push_back(m_idx);
      // Synchronized level is the sample taken S-1 edges ago; compare with one older.
      rise = hist[hist.size()-S] & ~hist[hist.size()-S-1];
      cap  = rise & ~bus.mask_i;
      ld   = (m_pend != '0) && (!m_valid || bus.evt_ready_i);
      taken = '0;
      if (ld) begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         taken[g] = 1'b1;
         m_idx    = g;
         m_valid  = 1'b1;
         m_ptr    = (g + 1) % N;
      end else if (bus.evt_ready_i) begin
         m_valid = 1'b0;
      end
      set_ovf = '0;
      for (int i = 0; i < N; i++)
         if (cap[i] && m_pend[i] && !taken[i]) set_ovf[i] = 1'b1;
      if (bus.ovf_clr_i) m_ovf = '0;
      m_ovf  = m_ovf | set_ovf;
      m_pend = (m_pend & ~taken) | cap;
      hist.push_back(bus.async_i);
      if (hist.size() > S + 1) void'(hist.pop_front());
   endtask

   // Inputs change at posedge+1; the model runs at posedge+2 on stable inputs.
   always @(posedge clk) begin
      #2;
      if (!rst_n) model_reset();
      else        model_step();
   end

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      check("valid", bus.evt_valid_o, obs_valid);
      check("pending", bus.pending_o, obs_pend_any);
      check("ovf", bus.ovf_o, obs_ovf);
      if (obs_valid) check("idx", bus.evt_idx_o, obs_idx);
      if (rst_n && bus.evt_valid_o && bus.evt_ready_i) begin
         seen_q.push_back(int'(bus.evt_idx_o));
         if (exp_q.size() == 0) check("unexpected_event_sb_size", exp_q.size(), 1);
         else                   check("event_idx", bus.evt_idx_o, exp_q.pop_front());
      end
      if (rst_n) begin
         check("rv1_valid", bus1.evt_valid_o, 1'b0);
         check("rv1_pending", bus1.pending_o, 1'b0);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [N-1:0] v);
      bus.async_i = bus.async_i | v;
      tick(3);
      bus.async_i = bus.async_i & ~v;
      tick(3);
   endtask

   task automatic expect_seen(input string name, input int e[$]);
      check({name, "_count"}, seen_q.size(), e.size());
      for (int k = 0; k < e.size() && k < seen_q.size(); k++) check(name, seen_q[k], e[k]);
      seen_q = {};
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int e[$];
      rst_n = 1'b0;
      bus.async_i = '0; bus.mask_i = '0; bus.evt_ready_i = 1'b0; bus.ovf_clr_i = 1'b0;
      bus1.async_i = '1; bus1.mask_i = '0; bus1.evt_ready_i = 1'b1; bus1.ovf_clr_i = 1'b0;
      tick(3);
      check("rst_valid", bus.evt_valid_o, 1'b0);
      check("rst_idx", bus.evt_idx_o, 0);
      check("rst_pending", bus.pending_o, 1'b0);
      check("rst_ovf", bus.ovf_o, 0);
      rst_n = 1'b1;
      tick(2);

      // Single event: latency STAGES+1 and one-cycle handshake.
      bus.evt_ready_i = 1'b1;
      bus.async_i[2]  = 1'b1;
      tick(4);
      check("single_valid_e3", bus.evt_valid_o, 1'b1);
      check("single_idx_e3", bus.evt_idx_o, 2);
      check("single_ovf", bus.ovf_o, 0);
      tick(1);
      check("single_valid_e4", bus.evt_valid_o, 1'b0);
      bus.async_i[2] = 1'b0;
      tick(4);
      e = '{2}; expect_seen("single", e);

      // Round-robin: pointer to 0, then all four; pointer to 2, then all four.
      pulse(4'b1000); tick(2);
      pulse(4'b1111); tick(3);
      e = '{3, 0, 1, 2, 3}; expect_seen("rr_from0", e);
      pulse(4'b0010); tick(2);
      pulse(4'b1111); tick(3);
      e = '{1, 2, 3, 0, 1}; expect_seen("rr_from2", e);

      // Backpressure with a second edge on the stalled source.
      bus.evt_ready_i = 1'b0;
      pulse(4'b0010);
      pulse(4'b0010);
      tick(2);
      check("bp_valid", bus.evt_valid_o, 1'b1);
      check("bp_idx", bus.evt_idx_o, 1);
      check("bp_pending", bus.pending_o, 1'b1);
      check("bp_ovf", bus.ovf_o, 0);
      bus.evt_ready_i = 1'b1;
      tick(4);
      e = '{1, 1}; expect_seen("bp", e);

      // Overflow, clear, and clear coinciding with a new overflow.
      bus.evt_ready_i = 1'b0;
      pulse(4'b0001);
      pulse(4'b1000);
      pulse(4'b1000);
      check("ovf_set", bus.ovf_o, 4'b1000);
      check("ovf_one_pending", bus.pending_o, 1'b1);
      bus.ovf_clr_i = 1'b1; tick(1); bus.ovf_clr_i = 1'b0;
      check("ovf_cleared", bus.ovf_o, 0);
      bus.async_i[3] = 1'b1;
      tick(2);
      bus.ovf_clr_i = 1'b1; tick(1); bus.ovf_clr_i = 1'b0;
      check("ovf_set_wins", bus.ovf_o, 4'b1000);
      bus.async_i[3] = 1'b0;
      tick(3);
      bus.evt_ready_i = 1'b1;
      tick(4);
      e = '{0, 3}; expect_seen("ovf_drain", e);
      bus.ovf_clr_i = 1'b1; tick(1); bus.ovf_clr_i = 1'b0;

      // Masked edge is dropped; mask after capture does not cancel.
      bus.mask_i = 4'b0001;
      pulse(4'b0001); tick(2);
      check("mask_pending", bus.pending_o, 1'b0);
      bus.mask_i = '0;
      e = {}; expect_seen("mask_drop", e);
      bus.evt_ready_i = 1'b0;
      pulse(4'b0100);
      bus.async_i[0] = 1'b1;
      tick(3);
      bus.mask_i = 4'b0001;
      bus.async_i[0] = 1'b0;
      tick(3);
      bus.evt_ready_i = 1'b1;
      tick(4);
      e = '{2, 0}; expect_seen("mask_late", e);
      bus.mask_i = '0;

      // Reset with three pending and one presented.
      bus.evt_ready_i = 1'b0;
      pulse(4'b1111);
      check("prerst_valid", bus.evt_valid_o, 1'b1);
      check("prerst_pending", bus.pending_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", bus.evt_valid_o, 1'b0);
      check("arst_idx", bus.evt_idx_o, 0);
      check("arst_pending", bus.pending_o, 1'b0);
      check("arst_ovf", bus.ovf_o, 0);
      tick(2);
      rst_n = 1'b1;
      bus.evt_ready_i = 1'b1;
      tick(6);
      e = {}; expect_seen("post_rst", e);

      // Randomized traffic, with one reset in the middle.
      for (int c = 0; c < 800; c++) begin
         bus.evt_ready_i = ($urandom_range(0, 9) < 7);
         bus.ovf_clr_i   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0) bus.mask_i = N'($urandom);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 3) == 0) bus.async_i[i] = ~bus.async_i[i];
         if (c == 400) rst_n = 1'b0;
         if (c == 402) rst_n = 1'b1;
         tick(1);
      end
      bus.async_i = '0; bus.mask_i = '0; bus.ovf_clr_i = 1'b0; bus.evt_ready_i = 1'b1;
      tick(12);
      check("scoreboard_empty", exp_q.size(), 0);
      check("drain_valid", bus.evt_valid_o, 1'b0);
      seen_q = {};

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
